// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipe_stage_skid inter-stage register.
//   - stage_state_e : FSM encoding (2'b11 is illegal and recovers to EMPTY)
//   - *_W_DEF       : default widths for the control, data and stall-counter fields
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,  // main and skid empty
        FULL  = 2'b01,  // main occupied, skid empty
        SKID  = 2'b10   // main and skid occupied
    } stage_state_e;

    localparam int CTRL_W_DEF = 8;
    localparam int DATA_W_DEF = 128;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one storage slot of the skid stage (control + data in one register).
// Ports:
//   clk_i  in   clock
//   rst_i  in   async active-low clear
//   ld_i   in   load enable
//   d_i    in   W-bit value to load
//   q_o    out  W-bit stored value
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)    q_o <= '0;
        else if (ld_i) q_o <= d_i;
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: parametrised valid/ready pipeline register with a 2-entry
// skid buffer so in_ready_o comes straight from a flop. Bubbles (and flushed
// slots) drive ctrl_o to zero so they never write architectural state.
// Optional feature macro: PIPE_STAGE_PERF_EN adds a saturating stall counter.
// Ports:
//   clk_i        in   clock
//   rst_i        in   async active-low reset
//   flush_i      in   synchronous flush, empties the stage, drops the input beat
//   in_valid_i   in   upstream beat valid
//   in_ready_o   out  stage can accept (registered)
//   ctrl_i       in   CTRL_W upstream control vector
//   data_i       in   DATA_W upstream payload
//   out_valid_o  out  downstream beat valid
//   out_ready_i  in   downstream accepts
//   ctrl_o       out  CTRL_W control, zero when not valid
//   data_o       out  DATA_W payload, holds last value when not valid
//   stall_cnt_o  out  CNT_W saturating stall count (PIPE_STAGE_PERF_EN only)
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
`ifdef PIPE_STAGE_PERF_EN
   ,parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
`ifdef PIPE_STAGE_PERF_EN
   ,output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    localparam int W = CTRL_W + DATA_W;

    stage_state_e state_q, state_d;
    logic         in_ready_q;
    logic         accept, transfer;
    logic         ld_main, ld_skid, main_from_skid;
    logic [W-1:0] main_q, skid_q, main_d;

    assign accept      = in_valid_i & in_ready_q;
    assign transfer    = out_valid_o & out_ready_i;
    assign out_valid_o = (state_q != EMPTY);
    assign in_ready_o  = in_ready_q;

    always_comb begin
        state_d        = state_q;
        ld_main        = 1'b0;
        ld_skid        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: if (accept) begin
                state_d = FULL;
                ld_main = 1'b1;
            end
            FULL: begin
                if (accept && transfer) begin
                    ld_main = 1'b1;
                end else if (accept) begin
                    state_d = SKID;
                    ld_skid = 1'b1;
                end else if (transfer) begin
                    state_d = EMPTY;
                end
            end
            SKID: if (transfer) begin
                state_d        = FULL;
                ld_main        = 1'b1;
                main_from_skid = 1'b1;
            end
            default: state_d = EMPTY;  // illegal 2'b11
        endcase
        // Flush overrides everything; no slot loads so data_o keeps its value.
        if (flush_i) begin
            state_d        = EMPTY;
            ld_main        = 1'b0;
            ld_skid        = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            // Ready is registered from the next state: only SKID blocks input.
            in_ready_q <= (state_d != SKID);
        end
    end

    assign main_d = main_from_skid ? skid_q : {ctrl_i, data_i};

    pipe_slot #(.W(W)) u_main (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ld_i  (ld_main),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_slot #(.W(W)) u_skid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ld_i  (ld_skid),
        .d_i   ({ctrl_i, data_i}),
        .q_o   (skid_q)
    );

    assign ctrl_o = main_q[W-1:DATA_W] & {CTRL_W{out_valid_o}};
    assign data_o = main_q[DATA_W-1:0];

`ifdef PIPE_STAGE_PERF_EN
    // Counts cycles a valid beat is held by downstream; reset is the only clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            stall_cnt_o <= '0;
        else if (out_valid_o && !out_ready_i && (stall_cnt_o != {CNT_W{1'b1}}))
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid: reset, streaming,
// backpressure through the skid slot, flush, async reset mid-stream and,
// when PIPE_STAGE_PERF_EN is defined, the saturating stall counter (CNT_W=4).
module tb_pipe_stage_skid;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 128;
`ifdef PIPE_STAGE_PERF_EN
    localparam int CNT_W  = 4;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] data_o;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    pipe_stage_skid #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
`ifdef PIPE_STAGE_PERF_EN
       ,.CNT_W  (CNT_W)
`endif
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .ctrl_i      (ctrl_i),
        .data_i      (data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .ctrl_o      (ctrl_o),
        .data_o      (data_o)
`ifdef PIPE_STAGE_PERF_EN
       ,.stall_cnt_o (stall_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d);
        in_valid_i = v;
        data_i     = d;
        ctrl_i     = d[CTRL_W-1:0];
    endtask

    initial begin
        rst_i       = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        ctrl_i      = 8'hFF;
        data_i      = 128'hAB;

        // Reset held with a valid beat presented
        tick();
        tick();
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_ctrl",      ctrl_o,      0);
        chk("rst_data",      data_o,      0);
        chk("rst_in_ready",  in_ready_o,  1);
        rst_i = 1'b1;
        tick();
        chk("post_rst_valid", out_valid_o, 1);
        chk("post_rst_ctrl",  ctrl_o,      8'hFF);
        chk("post_rst_data",  data_o,      128'hAB);
        drive(1'b0, 0);
        tick();
        chk("drain_valid", out_valid_o, 0);
        chk("drain_ctrl",  ctrl_o,      0);
        chk("drain_hold",  data_o,      128'hAB);

        // Streaming 1..8 with no gaps
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DATA_W'(i));
            tick();
            chk($sformatf("stream_valid_%0d", i), out_valid_o, 1);
            chk($sformatf("stream_data_%0d", i),  data_o,      DATA_W'(i));
            chk($sformatf("stream_ready_%0d", i), in_ready_o,  1);
        end
        drive(1'b0, 0);
        tick();
        chk("stream_end_valid", out_valid_o, 0);

        // Backpressure: 5 in main, 6 in skid, 7 held upstream
        out_ready_i = 1'b0;
        drive(1'b1, 5);
        tick();
        chk("bp_main5",   data_o,     5);
        chk("bp_ready_a", in_ready_o, 1);
        drive(1'b1, 6);
        tick();
        chk("bp_still5",  data_o,     5);
        chk("bp_ready_b", in_ready_o, 0);
        drive(1'b1, 7);
        tick();
        chk("bp_hold5",   data_o,     5);
        chk("bp_ready_c", in_ready_o, 0);
        chk("bp_ctrl5",   ctrl_o,     5);
        out_ready_i = 1'b1;
        tick();
        chk("bp_out6",     data_o,     6);
        chk("bp_ready_d",  in_ready_o, 1);
        tick();
        chk("bp_out7",     data_o,     7);
        chk("bp_valid7",   out_valid_o, 1);
        drive(1'b0, 0);
        tick();
        chk("bp_end_valid", out_valid_o, 0);

        // Flush while in SKID with a new beat offered
        out_ready_i = 1'b0;
        drive(1'b1, 5);
        tick();
        drive(1'b1, 6);
        tick();
        chk("fl_skid_ready", in_ready_o, 0);
        drive(1'b1, 9);
        flush_i = 1'b1;
        tick();
        chk("fl_valid", out_valid_o, 0);
        chk("fl_ctrl",  ctrl_o,      0);
        chk("fl_ready", in_ready_o,  1);
        chk("fl_hold",  data_o,      5);
        flush_i = 1'b0;
        drive(1'b0, 0);
        out_ready_i = 1'b1;
        tick();
        chk("fl_no9_valid", out_valid_o, 0);
        chk("fl_no9_data",  data_o,      5);

        // Async reset pulse while FULL, no clock edge in between
        out_ready_i = 1'b0;
        drive(1'b1, 128'h33);
        tick();
        chk("ar_full", out_valid_o, 1);
        drive(1'b0, 0);
        #1 rst_i = 1'b0;
        #1;
        chk("ar_valid", out_valid_o, 0);
        chk("ar_ready", in_ready_o,  1);
        chk("ar_data",  data_o,      0);
        #1 rst_i = 1'b1;
        out_ready_i = 1'b1;
        drive(1'b1, 128'h44);
        tick();
        chk("ar_first_accept", data_o,      128'h44);
        chk("ar_first_valid",  out_valid_o, 1);
        drive(1'b0, 0);
        tick();

`ifdef PIPE_STAGE_PERF_EN
        // Stall counter: saturate at 15, survive a flush, clear on reset
        rst_i = 1'b0;
        #1;
        chk("perf_rst", stall_cnt_o, 0);
        rst_i = 1'b1;
        out_ready_i = 1'b0;
        drive(1'b1, 128'h77);
        repeat (5) tick();
        chk("perf_cnt4", stall_cnt_o, 4);
        repeat (15) tick();
        chk("perf_sat", stall_cnt_o, 15);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, 0);
        tick();
        chk("perf_flush_keep", stall_cnt_o, 15);
        rst_i = 1'b0;
        #1;
        chk("perf_rst_clear", stall_cnt_o, 0);
        rst_i = 1'b1;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
